// File: rtl/wb_regfile.sv
// Write-back stage and 16-entry register file with two combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write to matching read ports.
module wb_regfile #(
    parameter int LINK_REG = 15,
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stall,
    input  logic        regdst_in,
    input  logic        regwrite_in,
    input  logic [1:0]  memtoreg_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] mem_out_in,
    input  logic [15:0] link_in,
    input  logic [3:0]  reg_source_in,
    input  logic        rd_en1,
    input  logic        rd_en2,
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic [15:0] rd_data1,
    output logic [15:0] rd_data2,
    output logic        wb_valid,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [15:0] commit_count
);

    localparam logic [3:0] LINK_IDX = 4'(LINK_REG);

    logic [15:0] r_regs [NUM_REGS];
    logic [15:0] r_count;

    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_byp1;
    logic        w_byp2;

    assign w_addr = regdst_in ? LINK_IDX : reg_source_in;

    always_comb begin
        w_data = alu_out_in;
        case (memtoreg_in)
            2'b01:   w_data = mem_out_in;
            2'b10:   w_data = link_in;
            default: w_data = alu_out_in;
        endcase
    end

    // wb_valid is a qualifier without a ready: when high, the commit happens at the next edge.
    assign w_valid = regwrite_in & ~wb_stall & (w_addr != 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_count <= 16'h0000;
        end else if (w_valid) begin
            r_regs[w_addr] <= w_data;
            if (r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_valid && (rd_addr1 == w_addr);
    assign w_byp2 = w_valid && (rd_addr2 == w_addr);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // R0 is masked on the read side as well, so it reads zero regardless of storage.
    always_comb begin
        rd_data1 = 16'h0000;
        if (rd_en1 && (rd_addr1 != 4'd0)) begin
            rd_data1 = w_byp1 ? w_data : r_regs[rd_addr1];
        end
    end

    always_comb begin
        rd_data2 = 16'h0000;
        if (rd_en2 && (rd_addr2 != 4'd0)) begin
            rd_data2 = w_byp2 ? w_data : r_regs[rd_addr2];
        end
    end

    assign wb_valid     = w_valid;
    assign wb_addr      = w_addr;
    assign wb_data      = w_data;
    assign commit_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write-back select, R0/link, stall, flush,
// same-cycle read/write, asynchronous reset and counter saturation.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_stall;
    logic        regdst_in;
    logic        regwrite_in;
    logic [1:0]  memtoreg_in;
    logic [15:0] alu_out_in;
    logic [15:0] mem_out_in;
    logic [15:0] link_in;
    logic [3:0]  reg_source_in;
    logic        rd_en1;
    logic        rd_en2;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] commit_count;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .wb_stall      (wb_stall),
        .regdst_in     (regdst_in),
        .regwrite_in   (regwrite_in),
        .memtoreg_in   (memtoreg_in),
        .alu_out_in    (alu_out_in),
        .mem_out_in    (mem_out_in),
        .link_in       (link_in),
        .reg_source_in (reg_source_in),
        .rd_en1        (rd_en1),
        .rd_en2        (rd_en2),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .commit_count  (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_wb(input logic dst, input logic [3:0] src, input logic [1:0] sel,
                          input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] lnk);
        regwrite_in   = 1'b1;
        regdst_in     = dst;
        reg_source_in = src;
        memtoreg_in   = sel;
        alu_out_in    = alu;
        mem_out_in    = mem;
        link_in       = lnk;
    endtask

    task automatic edge_and_idle();
        @(posedge clk);
        #1;
        regwrite_in = 1'b0;
        wb_stall    = 1'b0;
        #1;
    endtask

    task automatic read1(input logic [3:0] addr);
        rd_en1   = 1'b1;
        rd_addr1 = addr;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wb_stall = 1'b0;
        regdst_in = 1'b0;
        regwrite_in = 1'b0;
        memtoreg_in = 2'b00;
        alu_out_in = 16'h0000;
        mem_out_in = 16'h0000;
        link_in = 16'h0000;
        reg_source_in = 4'd0;
        rd_en1 = 1'b1;
        rd_en2 = 1'b1;
        rd_addr1 = 4'd5;
        rd_addr2 = 4'd15;

        #2;
        check("reset_count", commit_count, 16'h0000);
        check("reset_rd1", rd_data1, 16'h0000);
        check("reset_rd2", rd_data2, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Memory select into R5
        set_wb(1'b0, 4'd5, 2'b01, 16'h1234, 16'hBEEF, 16'h0042);
        #1;
        check("sel_mem_valid", {15'd0, wb_valid}, 16'h0001);
        check("sel_mem_addr", {12'd0, wb_addr}, 16'h0005);
        check("sel_mem_data", wb_data, 16'hBEEF);
        edge_and_idle();
        read1(4'd5);
        check("r5_mem", rd_data1, 16'hBEEF);
        check("count_1", commit_count, 16'h0001);

        // Code 11 selects ALU
        set_wb(1'b0, 4'd5, 2'b11, 16'h1234, 16'hBEEF, 16'h0042);
        edge_and_idle();
        read1(4'd5);
        check("r5_alu11", rd_data1, 16'h1234);
        check("count_2", commit_count, 16'h0002);

        // Link write goes to R15 regardless of reg_source
        set_wb(1'b1, 4'd5, 2'b10, 16'h1111, 16'h2222, 16'h0042);
        #1;
        check("link_addr", {12'd0, wb_addr}, 16'h000F);
        check("link_data", wb_data, 16'h0042);
        edge_and_idle();
        read1(4'd15);
        check("r15_link", rd_data1, 16'h0042);
        read1(4'd5);
        check("r5_untouched", rd_data1, 16'h1234);
        check("count_3", commit_count, 16'h0003);

        // Write to R0 is dropped
        set_wb(1'b0, 4'd0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000);
        #1;
        check("r0_valid", {15'd0, wb_valid}, 16'h0000);
        edge_and_idle();
        read1(4'd0);
        check("r0_read", rd_data1, 16'h0000);
        check("r0_count", commit_count, 16'h0003);

        // Stall holds the commit for 3 edges
        set_wb(1'b0, 4'd3, 2'b00, 16'h00AA, 16'h0000, 16'h0000);
        wb_stall = 1'b1;
        rd_addr2 = 4'd3;
        #1;
        check("stall_valid", {15'd0, wb_valid}, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("stall_r3", rd_data2, 16'h0000);
        check("stall_count", commit_count, 16'h0003);
        wb_stall = 1'b0;
        #1;
        check("unstall_valid", {15'd0, wb_valid}, 16'h0001);
        edge_and_idle();
        check("unstall_r3", rd_data2, 16'h00AA);
        check("unstall_count", commit_count, 16'h0004);

        // Flush arrives as regwrite_in=0
        set_wb(1'b0, 4'd4, 2'b00, 16'h5555, 16'h0000, 16'h0000);
        regwrite_in = 1'b0;
        #1;
        check("flush_valid", {15'd0, wb_valid}, 16'h0000);
        @(posedge clk);
        #1;
        read1(4'd4);
        check("flush_r4", rd_data1, 16'h0000);
        check("flush_count", commit_count, 16'h0004);

        // Same-cycle read and write of R7
        set_wb(1'b0, 4'd7, 2'b00, 16'h0011, 16'h0000, 16'h0000);
        edge_and_idle();
        set_wb(1'b0, 4'd7, 2'b00, 16'h0022, 16'h0000, 16'h0000);
        rd_addr2 = 4'd7;
        read1(4'd7);
`ifdef REGFILE_BYPASS_EN
        check("rw_same_pre1", rd_data1, 16'h0022);
        check("rw_same_pre2", rd_data2, 16'h0022);
`else
        check("rw_same_pre1", rd_data1, 16'h0011);
        check("rw_same_pre2", rd_data2, 16'h0011);
`endif
        edge_and_idle();
        check("rw_same_post1", rd_data1, 16'h0022);
        check("rw_same_post2", rd_data2, 16'h0022);
        check("rw_count", commit_count, 16'h0006);

        // Read enables low force zero
        rd_en1 = 1'b0;
        rd_en2 = 1'b0;
        #1;
        check("rden_low1", rd_data1, 16'h0000);
        check("rden_low2", rd_data2, 16'h0000);

        // Asynchronous reset mid-cycle with a pending commit to R9
        set_wb(1'b0, 4'd9, 2'b00, 16'h9999, 16'h0000, 16'h0000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", commit_count, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            read1(4'(i));
            check($sformatf("arst_r%0d", i), rd_data1, 16'h0000);
        end
        regwrite_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        read1(4'd9);
        check("arst_r9_dropped", rd_data1, 16'h0000);

        // Counter saturation: 65534, then 65535, then hold
        set_wb(1'b0, 4'd1, 2'b00, 16'h1357, 16'h0000, 16'h0000);
        repeat (65534) @(posedge clk);
        #1;
        check("count_fffe", commit_count, 16'hFFFE);
        @(posedge clk);
        #1;
        check("count_ffff", commit_count, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("count_sat", commit_count, 16'hFFFF);
        regwrite_in = 1'b0;
        read1(4'd1);
        check("sat_r1", rd_data1, 16'h1357);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
